// File: rtl/neopixel_frame_streamer.sv
// neopixel_frame_streamer: frame sequencer in front of a WS2812 pixel writer.
// Streams a RAM of RGB pixels over valid/busy, then holds the latch gap.
//
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   i_wr_en/addr/rgb     host pixel RAM write {r,g,b}; addr >= NUM_PIXELS dropped
//   i_start              frame request, level-sampled in IDLE only
//   i_busy               pixel writer busy
//   o_valid, o_red/green/blue   presented pixel (colour held until next LOAD)
//   o_frame_busy         frame in progress (LOAD..LATCH)
//   o_frame_done         one-cycle pulse in the DONE state
//
// Build option: define NEOPIXEL_AUTO_REFRESH_EN to add the periodic
// refresh counter; without it frames start only on i_start.
module neopixel_frame_streamer #(
  parameter int NUM_PIXELS     = 10,
  parameter int ADDR_W         = 4,
  parameter int LATCH_CYCLES   = 1000,
  parameter int REFRESH_CYCLES = 2097152
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [23:0]       i_wr_rgb,
  input  logic              i_start,
  input  logic              i_busy,
  output logic              o_valid,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  output logic              o_frame_busy,
  output logic              o_frame_done
);

  localparam int LW =
    (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LW-1:0] LAT_LAST =
    LW'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W:0] PIX_END =
    (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W:0] PIX_LAST =
    (ADDR_W+1)'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT,
    S_WAIT_TX,
    S_LATCH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] idx;
  logic [LW-1:0]     lat_cnt;
  logic [23:0]       rgb_q;
  logic              ref_hit;
  logic              frame_go;
  logic              more_pix;
  logic              idx_adv;
  logic              wr_ok;

  // Power-up contents are zero; reset deliberately leaves them alone.
  logic [23:0] mem [NUM_PIXELS] = '{default: 24'h0};

  assign wr_ok    = ({1'b0, i_wr_addr} < PIX_END);
  assign more_pix = ({1'b0, idx} < PIX_LAST);
  assign frame_go = (state == S_IDLE) && (i_start || ref_hit);
  assign idx_adv  = (state == S_WAIT_TX) && !i_busy && more_pix;

  always_ff @(posedge CLK) begin
    if (i_wr_en && wr_ok) begin
      mem[i_wr_addr] <= i_wr_rgb;
    end
  end

  // The read register doubles as the colour register: loaded only in
  // LOAD, so later RAM writes never disturb the pixel on the wire, and
  // a same-cycle write to the read address yields the old word.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rgb_q <= '0;
    end else if (state == S_LOAD) begin
      rgb_q <= mem[idx];
    end
  end

`ifdef NEOPIXEL_AUTO_REFRESH_EN
  localparam logic [21:0] REF_LAST =
    22'(REFRESH_CYCLES - 1);

  logic [21:0] ref_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ref_cnt <= '0;
    end else if (frame_go) begin
      ref_cnt <= '0;
    end else if (state == S_IDLE &&
                 ref_cnt != REF_LAST) begin
      ref_cnt <= ref_cnt + 22'd1;
    end
  end

  assign ref_hit = (state == S_IDLE) &&
                   (ref_cnt == REF_LAST);
`else
  assign ref_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx <= '0;
    end else if (frame_go) begin
      idx <= '0;
    end else if (idx_adv) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lat_cnt <= '0;
    end else if (state == S_LATCH) begin
      lat_cnt <= lat_cnt + LW'(1);
    end else begin
      lat_cnt <= '0;
    end
  end

  always_comb begin
    state_nx     = state;
    o_valid      = 1'b0;
    o_frame_busy = 1'b0;
    o_frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_go) state_nx = S_LOAD;
      end
      S_LOAD: begin
        o_frame_busy = 1'b1;
        state_nx     = S_PRESENT;
      end
      S_PRESENT: begin
        o_frame_busy = 1'b1;
        o_valid      = 1'b1;
        if (i_busy) state_nx = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        o_frame_busy = 1'b1;
        if (!i_busy) begin
          state_nx = more_pix ? S_LOAD : S_LATCH;
        end
      end
      S_LATCH: begin
        o_frame_busy = 1'b1;
        if (lat_cnt == LAT_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign o_red   = rgb_q[23:16];
  assign o_green = rgb_q[15:8];
  assign o_blue  = rgb_q[7:0];

endmodule
